// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: the carry chain is cut into STAGES chunks, one chunk per clock.
// Latency STAGES cycles, 1 beat/cycle; every stage freezes together while enable=0 or the output is stalled.
module pipelined_addsub #(
  parameter int DATA_WID = 8,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  input  logic                sub,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out,
  output logic                carry_out,
  output logic                overflow
);

  localparam int CW  = DATA_WID / STAGES;
  localparam int TOP = STAGES - 1;

  // Generate/propagate ripple across one chunk; returns {carry_out, sum}.
  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          ci);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CW; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[CW], p ^ c[CW-1:0]};
  endfunction

  logic                adv;
  logic [DATA_WID-1:0] b_eff;
  logic                c0;

  assign adv      = enable & (~out_valid | out_ready);
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = carry_in ^ sub;

  logic                f_vld;
  logic                f_sub;
  logic                f_ci;
  logic                f_co;
  logic                f_cmsb;
  logic                f_ovf;
  logic [CW-1:0]       f_a;
  logic [CW-1:0]       f_b;
  logic [CW-1:0]       f_sum;
  logic [DATA_WID-1:0] f_raw;
  logic [DATA_WID-1:0] f_res;

  // Stage k keeps finished result chunks 0..k plus the operand chunks not yet summed.
  for (genvar k = 0; k < TOP; k++) begin : g_st
    localparam int RW = (k + 1) * CW;
    localparam int OW = DATA_WID - RW;

    logic             vld_d;
    logic             sub_d;
    logic             ci_d;
    logic             co_d;
    logic [OW+CW-1:0] ua;
    logic [OW+CW-1:0] ub;
    logic [CW-1:0]    sum_d;
    logic [RW-1:0]    res_d;

    logic             vld;
    logic             sub_q;
    logic             cy;
    logic [RW-1:0]    res;
    logic [OW-1:0]    ra;
    logic [OW-1:0]    rb;

    if (k == 0) begin : g_head
      assign vld_d = in_valid;
      assign sub_d = sub;
      assign ci_d  = c0;
      assign ua    = a;
      assign ub    = b_eff;
      assign res_d = sum_d;
    end else begin : g_body
      assign vld_d = g_st[k-1].vld;
      assign sub_d = g_st[k-1].sub_q;
      assign ci_d  = g_st[k-1].cy;
      assign ua    = g_st[k-1].ra;
      assign ub    = g_st[k-1].rb;
      assign res_d = {sum_d, g_st[k-1].res};
    end

    assign {co_d, sum_d} = chunk_add(ua[CW-1:0], ub[CW-1:0], ci_d);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld   <= 1'b0;
        sub_q <= 1'b0;
        cy    <= 1'b0;
        res   <= '0;
        ra    <= '0;
        rb    <= '0;
      end else if (adv) begin
        vld   <= vld_d;
        sub_q <= sub_d;
        cy    <= co_d;
        res   <= res_d;
        ra    <= ua[OW+CW-1:CW];
        rb    <= ub[OW+CW-1:CW];
      end
    end
  end

  if (STAGES == 1) begin : g_single
    assign f_vld = in_valid;
    assign f_sub = sub;
    assign f_ci  = c0;
    assign f_a   = a;
    assign f_b   = b_eff;
    assign f_raw = f_sum;
  end else begin : g_multi
    assign f_vld = g_st[TOP-1].vld;
    assign f_sub = g_st[TOP-1].sub_q;
    assign f_ci  = g_st[TOP-1].cy;
    assign f_a   = g_st[TOP-1].ra;
    assign f_b   = g_st[TOP-1].rb;
    assign f_raw = {f_sum, g_st[TOP-1].res};
  end

  // Top chunk: the carry into the MSB is recovered from the MSB sum bit.
  assign {f_co, f_sum} = chunk_add(f_a, f_b, f_ci);
  assign f_cmsb        = f_a[CW-1] ^ f_b[CW-1] ^ f_sum[CW-1];
  assign f_ovf         = f_cmsb ^ f_co;
  assign f_res         = (SATURATE && f_ovf) ?
                         {f_a[CW-1], {(DATA_WID-1){~f_a[CW-1]}}} : f_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (adv) begin
      out_valid <= f_vld;
      out       <= f_res;
      carry_out <= f_co ^ f_sub;
      overflow  <= f_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Drives four pipelined_addsub configurations (8/2 wrap, 8/2 sat, 32/4 wrap, 8/1 sat) with shared beats
// and checks every result against a plain-arithmetic model through per-instance scoreboards.
module tb_pipelined_addsub;

  localparam int NDUT = 4;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            enable    = 1'b1;
  logic            out_ready = 1'b1;
  logic            sub_s     = 1'b0;
  logic            cin       = 1'b0;
  logic [31:0]     a32       = '0;
  logic [31:0]     b32       = '0;
  logic [NDUT-1:0] pend      = '0;
  logic [NDUT-1:0] ir;
  logic [NDUT-1:0] ovld;
  logic [NDUT-1:0] co_o;
  logic [NDUT-1:0] ov_o;
  logic [7:0]      o0;
  logic [7:0]      o1;
  logic [31:0]     o2;
  logic [7:0]      o3;
  logic [31:0]     od [NDUT];

  assign od[0] = {24'h0, o0};
  assign od[1] = {24'h0, o1};
  assign od[2] = o2;
  assign od[3] = {24'h0, o3};

  always #5 clk = ~clk;

  pipelined_addsub #(.DATA_WID(8), .STAGES(2), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(pend[0]), .in_ready(ir[0]),
    .a(a32[7:0]), .b(b32[7:0]), .sub(sub_s), .carry_in(cin), .out_valid(ovld[0]),
    .out_ready(out_ready), .out(o0), .carry_out(co_o[0]), .overflow(ov_o[0]));

  pipelined_addsub #(.DATA_WID(8), .STAGES(2), .SATURATE(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(pend[1]), .in_ready(ir[1]),
    .a(a32[7:0]), .b(b32[7:0]), .sub(sub_s), .carry_in(cin), .out_valid(ovld[1]),
    .out_ready(out_ready), .out(o1), .carry_out(co_o[1]), .overflow(ov_o[1]));

  pipelined_addsub #(.DATA_WID(32), .STAGES(4), .SATURATE(1'b0)) u_w32 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(pend[2]), .in_ready(ir[2]),
    .a(a32), .b(b32), .sub(sub_s), .carry_in(cin), .out_valid(ovld[2]),
    .out_ready(out_ready), .out(o2), .carry_out(co_o[2]), .overflow(ov_o[2]));

  pipelined_addsub #(.DATA_WID(8), .STAGES(1), .SATURATE(1'b1)) u_s8_1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(pend[3]), .in_ready(ir[3]),
    .a(a32[7:0]), .b(b32[7:0]), .sub(sub_s), .carry_in(cin), .out_valid(ovld[3]),
    .out_ready(out_ready), .out(o3), .carry_out(co_o[3]), .overflow(ov_o[3]));

  function automatic int wid(input int d);
    return (d == 2) ? 32 : 8;
  endfunction

  function automatic int stg(input int d);
    case (d)
      2:       return 4;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit satf(input int d);
    return (d == 1) || (d == 3);
  endfunction

  // Reference: exact integer arithmetic, returns {overflow, carry/borrow, result}.
  function automatic logic [33:0] model(input int w, input bit sat, input logic [31:0] x,
                                        input logic [31:0] y, input bit s, input bit ci);
    longint m, mx, mn, ux, uy, sx, sy, full, sres, res;
    bit co, ovf;
    m  = (longint'(1) << w) - 1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = (ux > mx) ? ux - m - 1 : ux;
    sy = (uy > mx) ? uy - m - 1 : uy;
    if (s) begin
      full = ux - uy - longint'(ci);
      co   = (full < 0);
      sres = sx - sy - longint'(ci);
    end else begin
      full = ux + uy + longint'(ci);
      co   = (full > m);
      sres = sx + sy + longint'(ci);
    end
    ovf = (sres > mx) || (sres < mn);
    res = full & m;
    if (sat && ovf) res = (sres > mx) ? mx : (mn & m);
    return {ovf, co, res[31:0]};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [33:0] q [NDUT][$];
  bit          held     [NDUT];
  logic [33:0] hold_val [NDUT];
  logic [33:0] m_got;
  logic [33:0] m_exp;

  function automatic int qtotal();
    int t = 0;
    for (int d = 0; d < NDUT; d++) t += q[d].size();
    return t;
  endfunction

  // Handshakes seen at a negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        m_got = {ov_o[d], co_o[d], od[d]};
        chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(enable & (~ovld[d] | out_ready)));
        if (held[d]) chk($sformatf("hold[%0d]", d), 64'({ovld[d], m_got}), 64'({1'b1, hold_val[d]}));
        held[d] = 1'b0;
        if (ovld[d]) begin
          if (enable && out_ready) begin
            if (q[d].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL extra_beat[%0d]: got out=0x%0h, expected no pending beat", d, od[d]);
            end else begin
              m_exp = q[d].pop_front();
              chk($sformatf("result[%0d]", d), 64'(m_got), 64'(m_exp));
            end
          end else begin
            held[d]     = 1'b1;
            hold_val[d] = m_got;
          end
        end
        if (pend[d] && ir[d]) q[d].push_back(model(wid(d), satf(d), a32, b32, sub_s, cin));
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic ci);
    logic [NDUT-1:0] acc;
    a32   = x;
    b32   = y;
    sub_s = s;
    cin   = ci;
    pend  = '1;
    for (int t = 0; t < 300 && pend != '0; t++) begin
      @(negedge clk);
      acc = pend & ir;
      @(posedge clk);
      #1;
      pend = pend & ~acc;
    end
    if (pend != '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got pending=0x%0h, expected 0", pend);
      pend = '0;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int t = 0; t < 100 && qtotal() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(qtotal()), 64'(0));
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FF7F;
      2:       return 32'h8000_0080;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic send_rand();
    send(rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  int first [NDUT];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    chk("model_add_7f",   64'(model(8,  1'b0, 32'd100, 32'd27, 1'b0, 1'b0)), 64'({1'b0, 1'b0, 32'h7F}));
    chk("model_add_ovf",  64'(model(8,  1'b0, 32'd100, 32'd28, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 32'h80}));
    chk("model_add_sat",  64'(model(8,  1'b1, 32'd100, 32'd28, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 32'h7F}));
    chk("model_chunk_cy", 64'(model(8,  1'b0, 32'h0F,  32'h01, 1'b0, 1'b0)), 64'({1'b0, 1'b0, 32'h10}));
    chk("model_cin_wrap", 64'(model(8,  1'b0, 32'hFF,  32'h00, 1'b0, 1'b1)), 64'({1'b0, 1'b1, 32'h00}));
    chk("model_sub_brw",  64'(model(8,  1'b0, 32'd5,   32'd7,  1'b1, 1'b0)), 64'({1'b0, 1'b1, 32'hFE}));
    chk("model_sub_ovf",  64'(model(8,  1'b0, 32'h80,  32'h01, 1'b1, 1'b0)), 64'({1'b1, 1'b0, 32'h7F}));
    chk("model_sub_sat",  64'(model(8,  1'b1, 32'h80,  32'h01, 1'b1, 1'b0)), 64'({1'b1, 1'b0, 32'h80}));
    chk("model_sub_bin",  64'(model(8,  1'b0, 32'd9,   32'd3,  1'b1, 1'b1)), 64'({1'b0, 1'b0, 32'h05}));
    chk("model_w32_ovf",  64'(model(32, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 32'h8000_0000}));
    chk("model_w32_sat",  64'(model(32, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 32'h7FFF_FFFF}));
    chk("model_w32_cy",   64'(model(32, 1'b0, 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b0, 1'b0, 32'h0100_0000}));

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_out[%0d]", d), 64'({ovld[d], co_o[d], ov_o[d], od[d]}), 64'(0));
      chk($sformatf("reset_in_ready[%0d]", d), 64'(ir[d]), 64'(1));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'd100, 32'd27, 1'b0, 1'b0);
    send(32'd100, 32'd28, 1'b0, 1'b0);
    send(32'h0F, 32'h01, 1'b0, 1'b0);
    send(32'hFF, 32'h00, 1'b0, 1'b1);
    send(32'd5, 32'd7, 1'b1, 1'b0);
    send(32'h80, 32'h01, 1'b1, 1'b0);
    send(32'd9, 32'd3, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0);
    drain();

    // Output stall in the middle of a 10-beat stream.
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Global freeze with the pipeline full.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 enable = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two beats in flight, then first-beat latency.
    send_rand();
    send_rand();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("async_reset[%0d]", d), 64'({ovld[d], co_o[d], ov_o[d], od[d]}), 64'(0));
      q[d].delete();
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd100, 32'd27, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) first[d] = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ovld[d] && first[d] == 0) first[d] = c;
    end
    for (int d = 0; d < NDUT; d++) chk($sformatf("latency[%0d]", d), 64'(first[d]), 64'(stg(d)));
    drain();

    // Random traffic with random backpressure and freezes.
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          send_rand();
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int c = 0; c < 500; c++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          enable    = ($urandom_range(0, 5) != 0);
        end
        out_ready = 1'b1;
        enable    = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor with carry/borrow-in and a valid/ready stream interface. The operand width is split into STAGES equal chunks, and the carry ripples one chunk per clock. Optional signed saturation. Successor to the team's combinational carry-chain adder for datapaths that need wide operands at high clock rates.

Parameters:
DATA_WID, 8, operand/result width in bits; must be a multiple of STAGES.
STAGES, 2, pipeline stages (1..DATA_WID); chunk width CW = DATA_WID/STAGES; latency = STAGES cycles.
SATURATE, 0, 1 = clamp signed overflow to max/min; 0 = wrap.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global run; 0 freezes the pipeline
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  DATA_WID  operand A
b  input  DATA_WID  operand B
sub  input  1  0 = A+B+cin, 1 = A-B-bin
carry_in  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out  output  DATA_WID  result (wrapped or saturated)
carry_out  output  1  unsigned carry (add) / borrow (sub), always from the unsaturated sum
overflow  output  1  signed overflow flag, always from the unsaturated sum

Behaviour:
- Arithmetic: bb = sub ? ~b : b; c0 = carry_in ^ sub; raw = a + bb + c0, DATA_WID+1 bits.
- carry_out = raw[DATA_WID] ^ sub, so 1 = borrow on sub.
- overflow = carry into MSB XOR carry out of MSB.
- SATURATE=1 and overflow: out = 0x7F..F if a[MSB]==0, else 0x80..0. Otherwise out = raw[DATA_WID-1:0].
- Pipeline: stage k (0..STAGES-1) computes chunk k with g/p generate-propagate ripple plus the registered carry from stage k-1.
- Upper operand chunks are skew-registered alongside. Lower result chunks are delay-registered so all chunks of one beat emerge together.
- Each stage holds a valid bit.
- Advance: adv = enable & (~out_valid | out_ready). All stages shift together when adv=1; no bubble collapse.
- in_ready = adv, a combinational function of enable, out_valid and out_ready.
- A beat is accepted when in_valid & in_ready.
- When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Latency: a beat accepted at edge N is presented at out_valid after edge N+STAGES-1, and stays there until out_ready.
- Throughput: 1 beat/cycle with out_ready held high.
- Output hold: while out_valid & ~out_ready, out/carry_out/overflow/out_valid are stable and no stage register changes.
- enable=0: in_ready=0 and all registers hold. out_valid may remain 1, but a handshake with out_ready=1 does not pop the beat until enable returns.
- STAGES=1: single registered stage; result appears one edge after acceptance.
- Reset, asynchronous and at any time including mid-stream: all valid bits 0, out_valid=0, out=0, carry_out=0, overflow=0. In-flight beats are discarded. in_ready=1 after reset if enable=1.
- Carry from the top chunk of stage k feeds stage k+1 only when that beat advances; no carry leaks between beats.
- Simultaneous pop and push with pipeline full and out_ready=1: allowed; no beat is lost or duplicated.

Test Plan:
- DATA_WID=8, STAGES=2, SATURATE=0: a=100,b=27,sub=0,cin=0 -> out=0x7F, ov=0, co=0 after 2 cycles. Then a=100,b=28 -> out=0x80, ov=1, co=0. Repeat with SATURATE=1 -> out=0x7F, ov=1.
- Cross-chunk carry: a=0x0F,b=0x01 -> out=0x10. a=0xFF,b=0x00,cin=1 -> out=0x00, co=1, ov=0.
- Subtract: a=5,b=7,sub=1,cin=0 -> out=0xFE, co=1 (borrow), ov=0. a=0x80,b=1,sub=1 -> out=0x7F, ov=1; with SATURATE=1 -> out=0x80. a=9,b=3,sub=1,cin=1 -> out=0x05, co=0.
- Backpressure: stream 10 random beats with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 10 results in order and matching the model, no duplicates.
- enable=0 for 4 cycles with the pipeline full -> no register change, in_ready=0. On resume, results continue in order.
- Assert rst_n=0 asynchronously with 2 beats in flight -> out_valid=0, out=0 immediately. After release, the first new beat appears after exactly STAGES cycles. Repeat the full suite with DATA_WID=32, STAGES=4.
